// File: rtl/sdram_cmd_sequencer.sv
// rtl/sdram_cmd_sequencer.sv - host request to SDRAM pin-level command sequencer
//
// Turns one accepted host request (mode program, burst write or burst read)
// into a registered CS/RAS/CAS/WE/BS/ADDR/SIZE command stream. The stream
// honours the programmed tpre/tcas/tlat/twait timing and the burst length.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   req_valid/req_ready   host request handshake (ready only in IDLE)
//   req_op/cfg/bank/row/col/size  request fields, latched at accept
//   wr_data/wr_valid/wr_ready     write beat stream (ready = beat consumed)
//   rd_data/rd_valid/rd_last      read beat stream, no backpressure
//   done                  one-cycle pulse on return to IDLE
//   sd_cs/ras/cas/we      SDRAM command pins, active-low
//   sd_bs/addr/size       bank, address/mode word, transfer size
//   sd_dout/sd_doe/sd_din write data pad, output enable, read data pad
module sdram_cmd_sequencer #(
    parameter logic [7:0] RST_TCAS  = 8'd3,
    parameter logic [7:0] RST_TWAIT = 8'd3,
    parameter logic [7:0] RST_TPRE  = 8'd3,
    parameter logic [3:0] RST_TLAT  = 4'd4,
    parameter logic [2:0] RST_BURST = 3'b010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_cfg,
    input  logic [1:0]  req_bank,
    input  logic [7:0]  req_row,
    input  logic [7:0]  req_col,
    input  logic [1:0]  req_size,
    input  logic [31:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        rd_last,
    output logic        done,
    output logic        sd_cs,
    output logic        sd_ras,
    output logic        sd_cas,
    output logic        sd_we,
    output logic [1:0]  sd_bs,
    output logic [31:0] sd_addr,
    output logic [1:0]  sd_size,
    output logic [31:0] sd_dout,
    output logic        sd_doe,
    input  logic [31:0] sd_din
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_MODE   = 4'd1;
    localparam logic [3:0] S_PRE    = 4'd2;
    localparam logic [3:0] S_PRE_W  = 4'd3;
    localparam logic [3:0] S_ACT    = 4'd4;
    localparam logic [3:0] S_ACT_W  = 4'd5;
    localparam logic [3:0] S_WR     = 4'd6;
    localparam logic [3:0] S_RD     = 4'd7;
    localparam logic [3:0] S_RD_LAT = 4'd8;
    localparam logic [3:0] S_RD_DAT = 4'd9;
    localparam logic [3:0] S_TWAIT  = 4'd10;

    // {CS,RAS,CAS,WE}
    localparam logic [3:0] CMD_MODE  = 4'b0000;
    localparam logic [3:0] CMD_PRE   = 4'b0001;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_NOP   = 4'b1111;
    localparam logic [3:0] CMD_BUSY  = 4'b1100;

    logic [3:0]  state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [7:0]  tcas_q, tcas_d, twait_q, twait_d, tpre_q, tpre_d;
    logic [3:0]  tlat_q, tlat_d;
    logic [2:0]  burst_q, burst_d;
    logic        is_rd_q, is_rd_d;
    logic [7:0]  row_q, row_d, col_q, col_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [1:0]  bs_q, bs_d, size_q, size_d;
    logic [31:0] addr_q, addr_d, dout_q, dout_d, rd_data_q, rd_data_d;
    logic        doe_q, doe_d, req_ready_q, req_ready_d, wr_ready_q, wr_ready_d;
    logic        rd_valid_q, rd_valid_d, rd_last_q, rd_last_d, done_q, done_d;
    logic [6:0]  bl;

    // Wait counters count down to zero, so a field value v gives v-1
    // extra cycles; a programmed 0 behaves like 1.
    function automatic logic [7:0] m1(input logic [7:0] v);
        return (v == 8'd0) ? 8'd0 : v - 8'd1;
    endfunction

    always_comb begin
        case (burst_q)
            3'd0:    bl = 7'd1;
            3'd1:    bl = 7'd2;
            3'd2:    bl = 7'd4;
            3'd3:    bl = 7'd8;
            3'd4:    bl = 7'd16;
            3'd5:    bl = 7'd32;
            default: bl = 7'd64;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        cnt_d       = cnt_q;
        tcas_d      = tcas_q;
        twait_d     = twait_q;
        tpre_d      = tpre_q;
        tlat_d      = tlat_q;
        burst_d     = burst_q;
        is_rd_d     = is_rd_q;
        row_d       = row_q;
        col_d       = col_q;
        cmd_d       = CMD_NOP;
        bs_d        = bs_q;
        size_d      = size_q;
        addr_d      = addr_q;
        dout_d      = dout_q;
        rd_data_d   = rd_data_q;
        doe_d       = 1'b0;
        req_ready_d = 1'b0;
        wr_ready_d  = 1'b0;
        rd_valid_d  = 1'b0;
        rd_last_d   = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid) begin
                    is_rd_d = (req_op == 2'b10);
                    row_d   = req_row;
                    col_d   = req_col;
                    case (req_op)
                        2'b00: begin
                            state_d     = S_MODE;
                            cmd_d       = CMD_MODE;
                            addr_d      = req_cfg;
                            req_ready_d = 1'b0;
                        end
                        2'b01, 2'b10: begin
                            state_d     = S_PRE;
                            cmd_d       = CMD_PRE;
                            bs_d        = req_bank;
                            size_d      = req_size;
                            wait_d      = m1(tpre_q);
                            req_ready_d = 1'b0;
                        end
                        default: ; // op 11: consumed, nothing issued
                    endcase
                end
            end
            S_MODE: begin
                // sd_addr still carries the program word during this cycle.
                // addr_mode only matters to the device, so it is not kept.
                tcas_d  = addr_q[31:24];
                twait_d = addr_q[23:16];
                tpre_d  = addr_q[15:8];
                tlat_d  = addr_q[7:4];
                burst_d = addr_q[2:0];
                state_d = S_TWAIT;
                wait_d  = m1(addr_q[23:16]);
            end
            S_PRE, S_PRE_W: begin
                if (wait_q == 8'd0) begin
                    state_d = S_ACT;
                    cmd_d   = CMD_ACT;
                    addr_d  = {24'b0, row_q};
                    wait_d  = m1(tcas_q);
                end else begin
                    state_d = S_PRE_W;
                    wait_d  = wait_q - 8'd1;
                end
            end
            S_ACT, S_ACT_W: begin
                if (wait_q != 8'd0) begin
                    state_d = S_ACT_W;
                    wait_d  = wait_q - 8'd1;
                end else if (is_rd_q) begin
                    state_d = S_RD;
                    cmd_d   = CMD_READ;
                    addr_d  = {24'b0, col_q};
                    wait_d  = m1({4'b0, tlat_q});
                end else if (wr_valid) begin
                    state_d    = S_WR;
                    cmd_d      = CMD_WRITE;
                    addr_d     = {24'b0, col_q};
                    dout_d     = wr_data;
                    doe_d      = 1'b1;
                    wr_ready_d = 1'b1;
                    cnt_d      = 7'd1;
                end else begin
                    // First beat is late: hold off WRITE with plain NOPs.
                    state_d = S_ACT_W;
                end
            end
            S_WR: begin
                if (cnt_q == bl) begin
                    state_d = S_TWAIT;
                    wait_d  = m1(twait_q);
                end else if (wr_valid) begin
                    dout_d     = wr_data;
                    doe_d      = 1'b1;
                    wr_ready_d = 1'b1;
                    cnt_d      = cnt_q + 7'd1;
                end else begin
                    cmd_d = CMD_BUSY;
                end
            end
            S_RD, S_RD_LAT: begin
                if (wait_q == 8'd0) begin
                    state_d = S_RD_DAT;
                    cnt_d   = 7'd0;
                end else begin
                    state_d = S_RD_LAT;
                    wait_d  = wait_q - 8'd1;
                end
            end
            S_RD_DAT: begin
                rd_valid_d = 1'b1;
                rd_data_d  = sd_din;
                cnt_d      = cnt_q + 7'd1;
                if (cnt_q + 7'd1 == bl) begin
                    rd_last_d = 1'b1;
                    state_d   = S_TWAIT;
                    wait_d    = m1(twait_q);
                end
            end
            S_TWAIT: begin
                if (wait_q == 8'd0) begin
                    state_d     = S_IDLE;
                    done_d      = 1'b1;
                    req_ready_d = 1'b1;
                    bs_d        = 2'b0;
                    size_d      = 2'b0;
                end else begin
                    wait_d = wait_q - 8'd1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            wait_q      <= 8'd0;
            cnt_q       <= 7'd0;
            tcas_q      <= RST_TCAS;
            twait_q     <= RST_TWAIT;
            tpre_q      <= RST_TPRE;
            tlat_q      <= RST_TLAT;
            burst_q     <= RST_BURST;
            is_rd_q     <= 1'b0;
            row_q       <= 8'd0;
            col_q       <= 8'd0;
            cmd_q       <= CMD_NOP;
            bs_q        <= 2'b0;
            size_q      <= 2'b0;
            addr_q      <= 32'd0;
            dout_q      <= 32'd0;
            rd_data_q   <= 32'd0;
            doe_q       <= 1'b0;
            req_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            cnt_q       <= cnt_d;
            tcas_q      <= tcas_d;
            twait_q     <= twait_d;
            tpre_q      <= tpre_d;
            tlat_q      <= tlat_d;
            burst_q     <= burst_d;
            is_rd_q     <= is_rd_d;
            row_q       <= row_d;
            col_q       <= col_d;
            cmd_q       <= cmd_d;
            bs_q        <= bs_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            rd_data_q   <= rd_data_d;
            doe_q       <= doe_d;
            req_ready_q <= req_ready_d;
            wr_ready_q  <= wr_ready_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            done_q      <= done_d;
        end
    end

    assign {sd_cs, sd_ras, sd_cas, sd_we} = cmd_q;
    assign sd_bs     = bs_q;
    assign sd_addr   = addr_q;
    assign sd_size   = size_q;
    assign sd_dout   = dout_q;
    assign sd_doe    = doe_q;
    assign req_ready = req_ready_q;
    assign wr_ready  = wr_ready_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
// tb/tb_sdram_cmd_sequencer.sv - self-checking bench for sdram_cmd_sequencer
module tb_sdram_cmd_sequencer;

    localparam int MAXC = 400;
    localparam logic [3:0] C_MODE = 4'b0000, C_PRE = 4'b0001, C_ACT = 4'b0011;
    localparam logic [3:0] C_WRITE = 4'b0100, C_READ = 4'b0101;
    localparam logic [3:0] C_NOP = 4'b1111, C_BUSY = 4'b1100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, req_valid, req_ready, wr_valid, wr_ready;
    logic [1:0]  req_op, req_bank, req_size, sd_bs, sd_size;
    logic [31:0] req_cfg, wr_data, rd_data, sd_addr, sd_dout, sd_din;
    logic [7:0]  req_row, req_col;
    logic        rd_valid, rd_last, done, sd_cs, sd_ras, sd_cas, sd_we, sd_doe;

    sdram_cmd_sequencer dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_cfg(req_cfg), .req_bank(req_bank), .req_row(req_row),
        .req_col(req_col), .req_size(req_size), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
        .done(done), .sd_cs(sd_cs), .sd_ras(sd_ras), .sd_cas(sd_cas), .sd_we(sd_we),
        .sd_bs(sd_bs), .sd_addr(sd_addr), .sd_size(sd_size), .sd_dout(sd_dout),
        .sd_doe(sd_doe), .sd_din(sd_din)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // stimulus and recorded DUT trace (index = cycles after the accept edge)
    bit          pat [MAXC];
    logic [31:0] din [MAXC];
    logic [31:0] wdat [64];
    logic [3:0]  t_cmd [MAXC];
    logic [31:0] t_addr [MAXC], t_dout [MAXC], t_rdat [MAXC];
    logic [1:0]  t_bs [MAXC], t_size [MAXC];
    logic        t_doe [MAXC], t_wr [MAXC], t_rv [MAXC], t_rl [MAXC], t_dn [MAXC], t_rdy [MAXC];
    int          n_rec, done_at;

    // reference expectations
    logic [3:0]  e_cmd [MAXC];
    logic [31:0] e_addr [MAXC], e_dout [MAXC], e_rdat [MAXC];
    logic        e_achk [MAXC], e_doe [MAXC], e_rv [MAXC], e_rl [MAXC], e_dn [MAXC], e_rdy [MAXC];
    int          e_done;

    // configuration the reference believes is programmed
    int m_tcas, m_twait, m_tpre, m_tlat, m_burst;

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int bl_of(input int b);
        return (b >= 6) ? 64 : (1 << b);
    endfunction

    task automatic model_rst();
        m_tcas = 3; m_twait = 3; m_tpre = 3; m_tlat = 4; m_burst = 2;
    endtask

    task automatic run_txn(input logic [1:0] op, input logic [1:0] bank, input logic [7:0] row,
                           input logic [7:0] col, input logic [1:0] size, input logic [31:0] cfg,
                           input int ss, input int sl, input bit rnd);
        int idx;
        int budget;
        for (int k = 0; k < MAXC; k++) begin
            pat[k] = rnd ? ($urandom_range(0, 3) != 0) : !(k >= ss && k < ss + sl);
            din[k] = $urandom;
        end
        for (int j = 0; j < 64; j++) wdat[j] = $urandom;
        budget = (op == 2'b11) ? 8 : MAXC;
        @(negedge clk);
        chk("req_ready_at_accept", -1, req_ready, 1);
        req_valid = 1; req_op = op; req_bank = bank; req_row = row; req_col = col;
        req_size = size; req_cfg = cfg;
        wr_valid = 1; idx = 0; wr_data = wdat[0];
        @(posedge clk);
        n_rec = budget; done_at = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            // request fields are don't-care after accept
            req_valid = 0; req_op = 2'($urandom); req_bank = 2'($urandom);
            req_row = 8'($urandom); req_col = 8'($urandom); req_size = 2'($urandom);
            req_cfg = $urandom;
            t_cmd[k] = {sd_cs, sd_ras, sd_cas, sd_we};
            t_addr[k] = sd_addr; t_dout[k] = sd_dout; t_rdat[k] = rd_data;
            t_bs[k] = sd_bs; t_size[k] = sd_size; t_doe[k] = sd_doe; t_wr[k] = wr_ready;
            t_rv[k] = rd_valid; t_rl[k] = rd_last; t_dn[k] = done; t_rdy[k] = req_ready;
            if (wr_ready && idx < 63) idx++;
            wr_data = wdat[idx]; wr_valid = pat[k]; sd_din = din[k];
            if (done) begin
                n_rec = k + 1;
                done_at = k;
                break;
            end
        end
        wr_valid = 0;
    endtask

    // Expected trace from the timing rules: events placed at computed cycle numbers.
    task automatic model(input logic [1:0] op, input logic [7:0] row, input logic [7:0] col,
                         input logic [31:0] cfg);
        int P, C, L, B, T, t, r, s;
        for (int k = 0; k < MAXC; k++) begin
            e_cmd[k] = C_NOP; e_addr[k] = 0; e_dout[k] = 0; e_rdat[k] = 0; e_achk[k] = 0;
            e_doe[k] = 0; e_rv[k] = 0; e_rl[k] = 0; e_dn[k] = 0; e_rdy[k] = 0;
        end
        e_done = -1;
        if (op == 2'b11) begin
            for (int k = 0; k < MAXC; k++) e_rdy[k] = 1;
            return;
        end
        if (op == 2'b00) begin
            e_cmd[0] = C_MODE; e_achk[0] = 1; e_addr[0] = cfg;
            m_tcas = int'(cfg[31:24]); m_twait = int'(cfg[23:16]); m_tpre = int'(cfg[15:8]);
            m_tlat = int'(cfg[7:4]); m_burst = int'(cfg[2:0]);
            e_done = 1 + eff(m_twait);
        end else begin
            P = eff(m_tpre); C = eff(m_tcas); L = eff(m_tlat); B = bl_of(m_burst); T = eff(m_twait);
            e_cmd[0] = C_PRE;
            e_cmd[P] = C_ACT; e_achk[P] = 1; e_addr[P] = {24'b0, row};
            if (op == 2'b01) begin
                t = P + C;
                while (t < MAXC - 1 && !pat[t-1]) t++;
                for (int j = 0; j < B; j++) begin
                    if (j > 0) begin
                        t++;
                        while (t < MAXC - 1 && !pat[t-1]) begin
                            e_cmd[t] = C_BUSY;
                            t++;
                        end
                    end
                    e_doe[t] = 1; e_dout[t] = wdat[j];
                    if (j == 0) begin
                        e_cmd[t] = C_WRITE; e_achk[t] = 1; e_addr[t] = {24'b0, col};
                    end
                end
                e_done = t + 1 + T;
            end else begin
                r = P + C;
                e_cmd[r] = C_READ; e_achk[r] = 1; e_addr[r] = {24'b0, col};
                for (int j = 0; j < B; j++) begin
                    s = r + L + j;
                    e_rv[s+1] = 1; e_rdat[s+1] = din[s]; e_rl[s+1] = (j == B - 1);
                end
                e_done = r + L + B + T;
            end
        end
        if (e_done >= MAXC) e_done = MAXC - 1;
        for (int k = e_done; k < MAXC; k++) e_rdy[k] = 1;
        e_dn[e_done] = 1;
    endtask

    task automatic compare(input logic [1:0] op, input logic [1:0] bank, input logic [1:0] size);
        for (int k = 0; k < n_rec; k++) begin
            chk("cmd", k, t_cmd[k], e_cmd[k]);
            chk("doe", k, t_doe[k], e_doe[k]);
            chk("wr_ready", k, t_wr[k], e_doe[k]);
            chk("rd_valid", k, t_rv[k], e_rv[k]);
            chk("rd_last", k, t_rl[k], e_rl[k]);
            chk("done", k, t_dn[k], e_dn[k]);
            chk("req_ready", k, t_rdy[k], e_rdy[k]);
            if (e_achk[k]) chk("sd_addr", k, t_addr[k], e_addr[k]);
            if (e_doe[k]) chk("sd_dout", k, t_dout[k], e_dout[k]);
            if (e_rv[k]) chk("rd_data", k, t_rdat[k], e_rdat[k]);
            if ((op == 2'b01 || op == 2'b10) && k < e_done) begin
                chk("sd_bs", k, t_bs[k], bank);
                chk("sd_size", k, t_size[k], size);
            end
        end
        chk("done_cycle", n_rec, done_at, e_done);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  bank;
        logic [7:0]  row;
        logic [7:0]  col;
        logic [1:0]  size;
        logic [31:0] cfg;
        int          ss;
        int          sl;
        int          x_first;
        int          x_beats;
        int          x_done;
    } vec_t;

    vec_t vt [13];

    initial begin
        int first, beats;
        vt[0]  = '{2'b01, 2'd0, 8'hAA, 8'h05, 2'd0, 32'h0, -1, 0, 6, 4, 13};
        vt[1]  = '{2'b10, 2'd0, 8'hAA, 8'h05, 2'd0, 32'h0, -1, 0, 6, 4, 17};
        vt[2]  = '{2'b00, 2'd0, 8'h00, 8'h00, 2'd0, 32'h03030342, -1, 0, 0, 0, 4};
        vt[3]  = '{2'b00, 2'd0, 8'h00, 8'h00, 2'd0, 32'h03030343, -1, 0, 0, 0, 4};
        vt[4]  = '{2'b01, 2'd1, 8'h3C, 8'h81, 2'd1, 32'h0, 8, 2, 6, 8, 19};
        vt[5]  = '{2'b00, 2'd0, 8'h00, 8'h00, 2'd0, 32'h03030347, -1, 0, 0, 0, 4};
        vt[6]  = '{2'b10, 2'd2, 8'h10, 8'h20, 2'd2, 32'h0, -1, 0, 6, 64, 77};
        vt[7]  = '{2'b11, 2'd0, 8'h00, 8'h00, 2'd0, 32'h0, -1, 0, -1, 0, -1};
        vt[8]  = '{2'b00, 2'd0, 8'h00, 8'h00, 2'd0, 32'h00000000, -1, 0, 0, 0, 2};
        vt[9]  = '{2'b01, 2'd3, 8'hFF, 8'h00, 2'd2, 32'h0, -1, 0, 2, 1, 4};
        vt[10] = '{2'b10, 2'd3, 8'hFF, 8'h00, 2'd2, 32'h0, -1, 0, 2, 1, 5};
        vt[11] = '{2'b00, 2'd0, 8'h00, 8'h00, 2'd0, 32'h02010213, -1, 0, 0, 0, 2};
        vt[12] = '{2'b01, 2'd2, 8'h44, 8'h66, 2'd0, 32'h0, 3, 2, 6, 8, 15};

        reset = 0; req_valid = 0; req_op = 0; req_cfg = 0; req_bank = 0; req_row = 0;
        req_col = 0; req_size = 0; wr_data = 0; wr_valid = 0; sd_din = 0;
        model_rst();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd", 0, {sd_cs, sd_ras, sd_cas, sd_we}, C_NOP);
        chk("rst_req_ready", 0, req_ready, 1);
        chk("rst_doe", 0, sd_doe, 0);
        reset = 1;

        // reset asserted in the middle of a write burst
        @(negedge clk);
        req_valid = 1; req_op = 2'b01; req_bank = 2'd2; req_row = 8'h12; req_col = 8'h34;
        req_size = 2'd1; wr_valid = 1; wr_data = 32'h1234_5678;
        @(negedge clk);
        req_valid = 0;
        repeat (7) @(negedge clk);
        chk("burst_in_progress", 7, wr_ready, 1);
        reset = 0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_cmd", 0, {sd_cs, sd_ras, sd_cas, sd_we}, C_NOP);
        chk("abort_doe", 0, sd_doe, 0);
        chk("abort_req_ready", 0, req_ready, 1);
        chk("abort_wr_ready", 0, wr_ready, 0);
        chk("abort_bs", 0, sd_bs, 0);
        chk("abort_addr", 0, sd_addr, 0);
        chk("abort_done", 0, done, 0);
        wr_valid = 0;
        reset = 1;
        model_rst();
        @(negedge clk);
        chk("post_release_cmd", 0, {sd_cs, sd_ras, sd_cas, sd_we}, C_NOP);

        // directed table
        for (int i = 0; i < 13; i++) begin
            run_txn(vt[i].op, vt[i].bank, vt[i].row, vt[i].col, vt[i].size, vt[i].cfg,
                    vt[i].ss, vt[i].sl, 1'b0);
            model(vt[i].op, vt[i].row, vt[i].col, vt[i].cfg);
            compare(vt[i].op, vt[i].bank, vt[i].size);
            first = -1; beats = 0;
            for (int k = 0; k < n_rec; k++) begin
                if (first < 0 && (t_cmd[k] == C_MODE || t_cmd[k] == C_WRITE || t_cmd[k] == C_READ))
                    first = k;
                if (t_wr[k] || t_rv[k]) beats++;
            end
            chk("vec_first_cmd", i, first, vt[i].x_first);
            chk("vec_beats", i, beats, vt[i].x_beats);
            chk("vec_done", i, done_at, vt[i].x_done);
        end

        // randomized transactions against the reference model
        for (int i = 0; i < 30; i++) begin
            logic [1:0]  op;
            logic [31:0] cfg;
            logic [1:0]  bank, size;
            logic [7:0]  row, col;
            op = 2'($urandom_range(0, 3));
            cfg = {8'($urandom_range(0, 4)), 8'($urandom_range(0, 4)), 8'($urandom_range(0, 4)),
                   4'($urandom_range(0, 5)), 1'($urandom), 3'($urandom_range(0, 7))};
            bank = 2'($urandom); size = 2'($urandom_range(0, 2));
            row = 8'($urandom); col = 8'($urandom);
            run_txn(op, bank, row, col, size, cfg, -1, 0, 1'b1);
            model(op, row, col, cfg);
            compare(op, bank, size);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
